// File: rtl/instr_decode_stage_pkg.sv
// ============================================================================
// Module : instr_decode_stage_pkg
// Brief  : Op codes, RV32I/M encoding constants, instruction formats and
//          the per-entry flag bundle shared by the decode stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_decode_stage_pkg;

  // Internal op codes; OP_ILLEGAL must stay 0 so a cleared entry reads illegal-free zero.
  localparam logic [5:0] OP_ILLEGAL = 6'd0,
    OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL  = 6'd3,  OP_JALR  = 6'd4,
    OP_BEQ  = 6'd5,  OP_BNE   = 6'd6,  OP_BLT  = 6'd7,  OP_BGE   = 6'd8,
    OP_BLTU = 6'd9,  OP_BGEU  = 6'd10,
    OP_LB   = 6'd11, OP_LH    = 6'd12, OP_LW   = 6'd13, OP_LBU   = 6'd14, OP_LHU = 6'd15,
    OP_SB   = 6'd16, OP_SH    = 6'd17, OP_SW   = 6'd18,
    OP_ADDI = 6'd19, OP_SLTI  = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22,
    OP_ORI  = 6'd23, OP_ANDI  = 6'd24, OP_SLLI = 6'd25, OP_SRLI  = 6'd26, OP_SRAI = 6'd27,
    OP_ADD  = 6'd28, OP_SUB   = 6'd29, OP_SLL  = 6'd30, OP_SLT   = 6'd31,
    OP_SLTU = 6'd32, OP_XOR   = 6'd33, OP_SRL  = 6'd34, OP_SRA   = 6'd35,
    OP_OR   = 6'd36, OP_AND   = 6'd37,
    OP_FENCE = 6'd38, OP_ECALL = 6'd39, OP_EBREAK = 6'd40,
    OP_MUL  = 6'd41, OP_MULH  = 6'd42, OP_MULHSU = 6'd43, OP_MULHU = 6'd44,
    OP_DIV  = 6'd45, OP_DIVU  = 6'd46, OP_REM  = 6'd47, OP_REMU  = 6'd48;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111, OPC_AUIPC  = 7'b0010111,
                         OPC_JAL    = 7'b1101111, OPC_JALR   = 7'b1100111,
                         OPC_BRANCH = 7'b1100011, OPC_LOAD   = 7'b0000011,
                         OPC_STORE  = 7'b0100011, OPC_OPIMM  = 7'b0010011,
                         OPC_OP     = 7'b0110011, OPC_MISC   = 7'b0001111,
                         OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH
  } fmt_e;

  // Register/immediate usage flags carried alongside op, imm and pc.
  typedef struct packed {
    logic       rs1_v;
    logic [4:0] rs1;
    logic       rs2_v;
    logic [4:0] rs2;
    logic       rd_v;
    logic [4:0] rd;
    logic       imm_v;
    logic       illegal;
  } dec_flags_t;

  // 32-bit sign-extended immediate for the fixed-layout formats (shift-imm handled by caller).
  function automatic logic [31:0] fmt_imm(fmt_e f, logic [31:0] w);
    logic [31:0] imm;
    imm = 32'd0;
    case (f)
      FMT_I:   imm = {{20{w[31]}}, w[31:20]};
      FMT_S:   imm = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   imm = {w[31:12], 12'd0};
      FMT_J:   imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_decode_stage_rv_decode_comb.sv
// ============================================================================
// Module : rv_decode_comb
// Brief  : Purely combinational RV32I(+M) decoder: instruction word to op,
//          register usage, immediate and illegal flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv_decode_comb
  import instr_decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 6,
  parameter int EN_M = 0
) (
  input  logic [31:0]     instr_i,
  output logic [OP_W-1:0] op_o,
  output dec_flags_t      flags_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_sh_log;
  logic        w_sh_ari;
  logic [31:0] w_shamt;
  logic [5:0]  w_op;
  fmt_e        w_fmt;
  logic [31:0] w_imm32;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_use_rd;

  assign w_opc = instr_i[6:0];
  assign w_f3  = instr_i[14:12];
  assign w_f7  = instr_i[31:25];

  // RV64 shifts carry a 6-bit shamt, so the funct field above it shrinks by one bit.
  assign w_sh_log = (XLEN == 64) ? (instr_i[31:26] == 6'b000000) : (w_f7 == F7_BASE);
  assign w_sh_ari = (XLEN == 64) ? (instr_i[31:26] == 6'b010000) : (w_f7 == F7_ALT);
  assign w_shamt  = (XLEN == 64) ? {26'd0, instr_i[25:20]} : {27'd0, instr_i[24:20]};

  // Opcode/funct lookup; anything unmatched (incl. RV64-only OP-IMM-32/OP-32) stays illegal.
  always_comb begin
    w_op  = OP_ILLEGAL;
    w_fmt = FMT_NONE;
    case (w_opc)
      OPC_LUI:   begin w_op = OP_LUI;   w_fmt = FMT_U; end
      OPC_AUIPC: begin w_op = OP_AUIPC; w_fmt = FMT_U; end
      OPC_JAL:   begin w_op = OP_JAL;   w_fmt = FMT_J; end
      OPC_JALR:  if (w_f3 == 3'd0) begin w_op = OP_JALR; w_fmt = FMT_I; end
      OPC_BRANCH: begin
        w_fmt = FMT_B;
        case (w_f3)
          3'd0: w_op = OP_BEQ;
          3'd1: w_op = OP_BNE;
          3'd4: w_op = OP_BLT;
          3'd5: w_op = OP_BGE;
          3'd6: w_op = OP_BLTU;
          3'd7: w_op = OP_BGEU;
          default: w_fmt = FMT_NONE;
        endcase
      end
      OPC_LOAD: begin
        w_fmt = FMT_I;
        case (w_f3)
          3'd0: w_op = OP_LB;
          3'd1: w_op = OP_LH;
          3'd2: w_op = OP_LW;
          3'd4: w_op = OP_LBU;
          3'd5: w_op = OP_LHU;
          default: w_fmt = FMT_NONE;
        endcase
      end
      OPC_STORE: begin
        w_fmt = FMT_S;
        case (w_f3)
          3'd0: w_op = OP_SB;
          3'd1: w_op = OP_SH;
          3'd2: w_op = OP_SW;
          default: w_fmt = FMT_NONE;
        endcase
      end
      OPC_OPIMM: begin
        w_fmt = FMT_I;
        case (w_f3)
          3'd0: w_op = OP_ADDI;
          3'd2: w_op = OP_SLTI;
          3'd3: w_op = OP_SLTIU;
          3'd4: w_op = OP_XORI;
          3'd6: w_op = OP_ORI;
          3'd7: w_op = OP_ANDI;
          3'd1: begin
            w_fmt = w_sh_log ? FMT_SH : FMT_NONE;
            if (w_sh_log) w_op = OP_SLLI;
          end
          default: begin
            w_fmt = (w_sh_log || w_sh_ari) ? FMT_SH : FMT_NONE;
            if (w_sh_log)      w_op = OP_SRLI;
            else if (w_sh_ari) w_op = OP_SRAI;
          end
        endcase
      end
      OPC_OP: begin
        w_fmt = FMT_R;
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            3'd0: w_op = OP_ADD;
            3'd1: w_op = OP_SLL;
            3'd2: w_op = OP_SLT;
            3'd3: w_op = OP_SLTU;
            3'd4: w_op = OP_XOR;
            3'd5: w_op = OP_SRL;
            3'd6: w_op = OP_OR;
            default: w_op = OP_AND;
          endcase
        end else if (w_f7 == F7_ALT && w_f3 == 3'd0) begin
          w_op = OP_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == 3'd5) begin
          w_op = OP_SRA;
        end else if (w_f7 == F7_MULDIV && EN_M != 0) begin
          w_op = OP_MUL + {3'd0, w_f3};
        end else begin
          w_fmt = FMT_NONE;
        end
      end
      OPC_MISC:  if (w_f3 == 3'd0) w_op = OP_FENCE;
      OPC_SYSTEM: begin
        if (instr_i == 32'h0000_0073)      w_op = OP_ECALL;
        else if (instr_i == 32'h0010_0073) w_op = OP_EBREAK;
      end
      default: w_op = OP_ILLEGAL;
    endcase
  end

  assign w_use_rs1 = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_S) ||
                     (w_fmt == FMT_B) || (w_fmt == FMT_SH);
  assign w_use_rs2 = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
  assign w_use_rd  = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_U) ||
                     (w_fmt == FMT_J) || (w_fmt == FMT_SH);
  assign w_imm32   = (w_fmt == FMT_SH) ? w_shamt : fmt_imm(w_fmt, instr_i);

  assign op_o            = OP_W'(w_op);
  assign flags_o.rs1_v   = w_use_rs1;
  assign flags_o.rs1     = w_use_rs1 ? instr_i[19:15] : 5'd0;
  assign flags_o.rs2_v   = w_use_rs2;
  assign flags_o.rs2     = w_use_rs2 ? instr_i[24:20] : 5'd0;
  assign flags_o.rd      = w_use_rd ? instr_i[11:7] : 5'd0;
  assign flags_o.rd_v    = w_use_rd && (instr_i[11:7] != 5'd0);
  assign flags_o.imm_v   = (w_fmt != FMT_NONE) && (w_fmt != FMT_R);
  assign flags_o.illegal = (w_op == OP_ILLEGAL);
  assign imm_o           = XLEN'($signed(w_imm32));

endmodule

`default_nettype wire

// File: rtl/instr_decode_stage.sv
// ============================================================================
// Module : instr_decode_stage
// Brief  : Registered decode stage with valid/ready handshake, two-entry
//          skid buffering (main + skid) and synchronous flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 6,
  parameter int EN_M = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_op,
  output logic            out_rs1_v,
  output logic [4:0]      out_rs1,
  output logic            out_rs2_v,
  output logic [4:0]      out_rs2,
  output logic            out_rd_v,
  output logic [4:0]      out_rd,
  output logic            out_imm_v,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam int ENT_W = OP_W + $bits(dec_flags_t) + 2 * XLEN;

  localparam logic [1:0] ST_EMPTY = 2'd0,
                         ST_ONE   = 2'd1,
                         ST_TWO   = 2'd2;

  logic [OP_W-1:0]  w_dec_op;
  dec_flags_t       w_dec_flags;
  logic [XLEN-1:0]  w_dec_imm;
  logic [ENT_W-1:0] w_new;
  logic             w_accept;
  logic             w_pop;
  dec_flags_t       w_main_flags;

  logic [1:0]       state_q, state_d;
  logic [ENT_W-1:0] main_q, main_d;
  logic [ENT_W-1:0] skid_q, skid_d;

  rv_decode_comb #(
    .XLEN (XLEN),
    .OP_W (OP_W),
    .EN_M (EN_M)
  ) u_dec (
    .instr_i (in_instr),
    .op_o    (w_dec_op),
    .flags_o (w_dec_flags),
    .imm_o   (w_dec_imm)
  );

  assign w_new     = {w_dec_op, w_dec_flags, w_dec_imm, in_pc};
  // Handshake flags come straight from state so in_ready never sees out_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Next occupancy and entry contents; flush overrides any concurrent accept.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (w_accept) begin
          main_d  = w_new;
          state_d = ST_ONE;
        end
        ST_ONE: begin
          if (w_accept && !w_pop) begin
            skid_d  = w_new;
            state_d = ST_TWO;
          end else if (w_accept && w_pop) begin
            main_d  = w_new;
          end else if (w_pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: if (w_pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and entry registers; reset clears both entries immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign {out_op, w_main_flags, out_imm, out_pc} = main_q;
  assign out_rs1_v   = w_main_flags.rs1_v;
  assign out_rs1     = w_main_flags.rs1;
  assign out_rs2_v   = w_main_flags.rs2_v;
  assign out_rs2     = w_main_flags.rs2;
  assign out_rd_v    = w_main_flags.rd_v;
  assign out_rd      = w_main_flags.rd;
  assign out_imm_v   = w_main_flags.imm_v;
  assign out_illegal = w_main_flags.illegal;

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
// ============================================================================
// Module : tb_instr_decode_stage
// Brief  : Scoreboard bench for instr_decode_stage; two instances (M off/on)
//          share one stimulus stream and are checked against a mask/match
//          instruction table model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_decode_stage;
  import instr_decode_stage_pkg::*;

  typedef logic [89:0] ent_t;
  localparam int F_N = 0, F_R = 1, F_I = 2, F_S = 3, F_B = 4, F_U = 5, F_J = 6, F_SH = 7;
  localparam int NT = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_pc = 32'd0;

  logic        in_ready_w[2], out_valid_w[2], rs1v_w[2], rs2v_w[2], rdv_w[2], immv_w[2], ill_w[2];
  logic [5:0]  op_w[2];
  logic [4:0]  rs1_w[2], rs2_w[2], rd_w[2];
  logic [31:0] imm_w[2], pc_w[2];

  int checks = 0;
  int errors = 0;

  logic [31:0] t_mask[NT], t_match[NT];
  logic [5:0]  t_op[NT];
  int          t_fmt[NT];
  bit          t_m[NT];
  int          n_t = 0;
  ent_t        q[2][$];

  always #5 clk = ~clk;

  instr_decode_stage #(.XLEN(32), .OP_W(6), .EN_M(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_op(op_w[0]), .out_rs1_v(rs1v_w[0]), .out_rs1(rs1_w[0]), .out_rs2_v(rs2v_w[0]),
    .out_rs2(rs2_w[0]), .out_rd_v(rdv_w[0]), .out_rd(rd_w[0]), .out_imm_v(immv_w[0]),
    .out_imm(imm_w[0]), .out_pc(pc_w[0]), .out_illegal(ill_w[0]));

  instr_decode_stage #(.XLEN(32), .OP_W(6), .EN_M(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_op(op_w[1]), .out_rs1_v(rs1v_w[1]), .out_rs1(rs1_w[1]), .out_rs2_v(rs2v_w[1]),
    .out_rs2(rs2_w[1]), .out_rd_v(rdv_w[1]), .out_rd(rd_w[1]), .out_imm_v(immv_w[1]),
    .out_imm(imm_w[1]), .out_pc(pc_w[1]), .out_illegal(ill_w[1]));

  function automatic ent_t got(int d);
    return {op_w[d], rs1v_w[d], rs1_w[d], rs2v_w[d], rs2_w[d], rdv_w[d], rd_w[d],
            immv_w[d], imm_w[d], pc_w[d], ill_w[d]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] g, input logic [127:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, g, e);
    end
  endtask

  task automatic add(input logic [31:0] mk, input logic [31:0] mt, input logic [5:0] op,
                     input int fmt, input bit m);
    t_mask[n_t] = mk; t_match[n_t] = mt; t_op[n_t] = op; t_fmt[n_t] = fmt; t_m[n_t] = m;
    n_t++;
  endtask

  // Reference decode: first-principles table of masked encodings per mnemonic.
  function automatic ent_t model(logic [31:0] w, logic [31:0] pc, bit en_m);
    int hit = -1;
    int f;
    logic r1u, r2u, rdu, immu;
    logic [31:0] imm;
    for (int k = 0; k < NT; k++)
      if (((w & t_mask[k]) == t_match[k]) && (en_m || !t_m[k])) hit = k;
    if (hit < 0) return {6'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, pc, 1'b1};
    f    = t_fmt[hit];
    r1u  = (f == F_R || f == F_I || f == F_S || f == F_B || f == F_SH);
    r2u  = (f == F_R || f == F_S || f == F_B);
    rdu  = (f == F_R || f == F_I || f == F_U || f == F_J || f == F_SH);
    immu = (f == F_I || f == F_S || f == F_B || f == F_U || f == F_J || f == F_SH);
    case (f)
      F_I:  imm = 32'($signed(w) >>> 20);
      F_S:  imm = 32'(($signed(w) >>> 25) * 32) | 32'(w[11:7]);
      F_B:  imm = 32'(($signed(w) >>> 31) * 4096) | {20'd0, w[7], w[30:25], w[11:8], 1'b0};
      F_U:  imm = w & 32'hFFFF_F000;
      F_J:  imm = 32'(($signed(w) >>> 31) * (1 << 20)) | {12'd0, w[19:12], w[20], w[30:21], 1'b0};
      F_SH: imm = 32'(w[24:20]);
      default: imm = 32'd0;
    endcase
    return {t_op[hit], r1u, r1u ? w[19:15] : 5'd0, r2u, r2u ? w[24:20] : 5'd0,
            rdu && (w[11:7] != 5'd0), rdu ? w[11:7] : 5'd0, immu, imm, pc, 1'b0};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = $urandom & 32'hFFFF_FFFC;
    out_ready = ordy;
    flush     = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    if ($urandom_range(0, 9) < 3) return $urandom;
    k = $urandom_range(0, NT - 1);
    return ($urandom & ~t_mask[k]) | t_match[k];
  endfunction

  // Monitor: occupancy and head-of-queue compare each cycle, then apply this edge's transfers.
  always @(negedge clk) begin
    if (!rst_n) begin
      q[0].delete();
      q[1].delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit acc;
        acc = in_valid && (q[d].size() < 2);
        chk($sformatf("out_valid_dut%0d", d), 128'(out_valid_w[d]), 128'(q[d].size() != 0));
        chk($sformatf("in_ready_dut%0d", d), 128'(in_ready_w[d]), 128'(q[d].size() < 2));
        if (q[d].size() != 0) begin
          chk($sformatf("entry_dut%0d", d), 128'(got(d)), 128'(q[d][0]));
          if (out_ready) void'(q[d].pop_front());
        end
        if (flush) q[d].delete();
        else if (acc) q[d].push_back(model(in_instr, in_pc, d == 1));
      end
    end
  end

  initial begin
    add(32'h7F, 32'h37, OP_LUI, F_U, 0);        add(32'h7F, 32'h17, OP_AUIPC, F_U, 0);
    add(32'h7F, 32'h6F, OP_JAL, F_J, 0);        add(32'h707F, 32'h67, OP_JALR, F_I, 0);
    add(32'h707F, 32'h63, OP_BEQ, F_B, 0);      add(32'h707F, 32'h1063, OP_BNE, F_B, 0);
    add(32'h707F, 32'h4063, OP_BLT, F_B, 0);    add(32'h707F, 32'h5063, OP_BGE, F_B, 0);
    add(32'h707F, 32'h6063, OP_BLTU, F_B, 0);   add(32'h707F, 32'h7063, OP_BGEU, F_B, 0);
    add(32'h707F, 32'h03, OP_LB, F_I, 0);       add(32'h707F, 32'h1003, OP_LH, F_I, 0);
    add(32'h707F, 32'h2003, OP_LW, F_I, 0);     add(32'h707F, 32'h4003, OP_LBU, F_I, 0);
    add(32'h707F, 32'h5003, OP_LHU, F_I, 0);    add(32'h707F, 32'h23, OP_SB, F_S, 0);
    add(32'h707F, 32'h1023, OP_SH, F_S, 0);     add(32'h707F, 32'h2023, OP_SW, F_S, 0);
    add(32'h707F, 32'h13, OP_ADDI, F_I, 0);     add(32'h707F, 32'h2013, OP_SLTI, F_I, 0);
    add(32'h707F, 32'h3013, OP_SLTIU, F_I, 0);  add(32'h707F, 32'h4013, OP_XORI, F_I, 0);
    add(32'h707F, 32'h6013, OP_ORI, F_I, 0);    add(32'h707F, 32'h7013, OP_ANDI, F_I, 0);
    add(32'hFE00707F, 32'h1013, OP_SLLI, F_SH, 0);
    add(32'hFE00707F, 32'h5013, OP_SRLI, F_SH, 0);
    add(32'hFE00707F, 32'h40005013, OP_SRAI, F_SH, 0);
    add(32'hFE00707F, 32'h33, OP_ADD, F_R, 0);  add(32'hFE00707F, 32'h40000033, OP_SUB, F_R, 0);
    add(32'hFE00707F, 32'h1033, OP_SLL, F_R, 0); add(32'hFE00707F, 32'h2033, OP_SLT, F_R, 0);
    add(32'hFE00707F, 32'h3033, OP_SLTU, F_R, 0); add(32'hFE00707F, 32'h4033, OP_XOR, F_R, 0);
    add(32'hFE00707F, 32'h5033, OP_SRL, F_R, 0); add(32'hFE00707F, 32'h40005033, OP_SRA, F_R, 0);
    add(32'hFE00707F, 32'h6033, OP_OR, F_R, 0);  add(32'hFE00707F, 32'h7033, OP_AND, F_R, 0);
    add(32'h707F, 32'h0F, OP_FENCE, F_N, 0);
    add(32'hFFFFFFFF, 32'h73, OP_ECALL, F_N, 0); add(32'hFFFFFFFF, 32'h00100073, OP_EBREAK, F_N, 0);
    for (int k = 0; k < 8; k++)
      add(32'hFE00707F, 32'h02000033 | (k << 12), 6'(int'(OP_MUL) + k), F_R, 1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_out_valid%0d", d), 128'(out_valid_w[d]), 128'd0);
      chk($sformatf("reset_in_ready%0d", d), 128'(in_ready_w[d]), 128'd1);
      chk($sformatf("reset_data%0d", d), 128'(got(d)), 128'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // addi x1,x1,1000 straight through
    drive(1, 32'h3E80_8093, 1, 0);
    drive(0, 32'd0, 1, 0);
    @(negedge clk);
    chk("addi_op", 128'(op_w[0]), 128'(OP_ADDI));
    chk("addi_imm", 128'(imm_w[0]), 128'd1000);

    // three-word stream into a stalled consumer
    drive(1, 32'h3E80_8093, 0, 0);
    drive(1, 32'h4B00_8093, 0, 0);
    drive(1, 32'h5780_8093, 0, 0);
    @(negedge clk);
    chk("full_in_ready", 128'(in_ready_w[0]), 128'd0);
    drive(1, 32'h5780_8093, 1, 0);
    drive(1, 32'h5780_8093, 1, 0);
    repeat (3) drive(0, 32'd0, 1, 0);

    // mul with M off / on
    drive(1, 32'h0210_80B3, 1, 0);
    drive(0, 32'd0, 1, 0);
    @(negedge clk);
    chk("mul_illegal_m0", 128'(ill_w[0]), 128'd1);
    chk("mul_op_m0", 128'(op_w[0]), 128'd0);
    chk("mul_op_m1", 128'(op_w[1]), 128'(OP_MUL));
    chk("mul_rd_m1", 128'(rd_w[1]), 128'd1);

    // negative immediates
    drive(1, 32'hFFF0_8093, 1, 0);
    drive(1, 32'hFE20_8EE3, 1, 0);
    drive(0, 32'd0, 1, 0);
    @(negedge clk);
    chk("beq_imm", 128'(imm_w[0]), 128'(32'hFFFF_FFFC));
    drive(0, 32'd0, 1, 0);

    // flush while full, with a word offered
    drive(1, 32'h0010_0093, 0, 0);
    drive(1, 32'h0020_0093, 0, 0);
    drive(1, 32'h0030_0093, 0, 1);
    drive(0, 32'd0, 0, 0);
    @(negedge clk);
    chk("flush_out_valid", 128'(out_valid_w[0]), 128'd0);
    chk("flush_in_ready", 128'(in_ready_w[0]), 128'd1);
    drive(1, 32'h0040_0093, 1, 0);
    repeat (2) drive(0, 32'd0, 1, 0);

    // asynchronous reset while full
    drive(1, 32'h0050_0093, 0, 0);
    drive(1, 32'h0060_0093, 0, 0);
    drive(0, 32'd0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 128'(out_valid_w[0]), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 128'(in_ready_w[0]), 128'd1);
    chk("post_rst_data", 128'(got(1)), 128'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0);
    repeat (4) drive(0, 32'd0, 1, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
